// File: rtl/lsq_cfg_ram.sv
// lsq_cfg_ram: multi-write, multi-read side-table RAM for the LSQ.
// Self-clearing after reset, with per-port and per-partition gating.
module lsq_cfg_ram #(
    parameter int              DEPTH        = 16,
    parameter int              INDEX        = 4,
    parameter int              WIDTH        = 8,
    parameter int              NUM_WR_PORTS = 4,
    parameter int              NUM_RD_PORTS = 1,
    parameter int              NUM_PARTS    = 4,
    parameter int              SEQ_START    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int              BYPASS       = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WR_PORTS*INDEX-1:0]   addrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]   dataWr_i,
    input  logic [NUM_WR_PORTS-1:0]         wrEn_i,
    input  logic [NUM_WR_PORTS-1:0]         writePortGated_i,
    input  logic [NUM_RD_PORTS*INDEX-1:0]   addr_i,
    output logic [NUM_RD_PORTS*WIDTH-1:0]   data_o,
    input  logic [NUM_RD_PORTS-1:0]         readPortGated_i,
    input  logic [NUM_PARTS-1:0]            partitionGated_i,
    output logic                            ramReady_o
);

    localparam int PSIZE = DEPTH / NUM_PARTS;

    typedef enum logic {CLEAR, READY} state_t;

    state_t             state;
    logic [INDEX-1:0]   clr_ptr;
    logic [WIDTH-1:0]   clr_val;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]   ent_gated;
    logic [NUM_WR_PORTS-1:0] wr_q;

    if (DEPTH % NUM_PARTS != 0) begin : g_bad_parts
        $error("lsq_cfg_ram: DEPTH not a multiple of NUM_PARTS");
    end
    if (INDEX != $clog2(DEPTH)) begin : g_bad_index
        $error("lsq_cfg_ram: INDEX does not match DEPTH");
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_part
        assign ent_gated[i] = partitionGated_i[i / PSIZE];
    end

    assign clr_val = (SEQ_START != 0) ? WIDTH'(clr_ptr) : RESET_VAL;

    // A write qualifies only when the RAM is ready and nothing gates it.
    always_comb begin
        wr_q = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            wr_q[p] = reset & ramReady_o & wrEn_i[p] & ~writePortGated_i[p]
                    & ~ent_gated[addrWr_i[p*INDEX +: INDEX]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            ramReady_o <= 1'b0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == INDEX'(DEPTH - 1)) begin
                state      <= READY;
                ramReady_o <= 1'b1;
            end
        end
    end

    // Ascending port order makes the highest-numbered port win a conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= clr_val;
            end else begin
                for (int p = 0; p < NUM_WR_PORTS; p++) begin
                    if (wr_q[p]) begin
                        mem[addrWr_i[p*INDEX +: INDEX]] <= dataWr_i[p*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        logic [INDEX-1:0] ra;
        logic [WIDTH-1:0] rd;
        data_o = '0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            ra = addr_i[r*INDEX +: INDEX];
            rd = mem[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WR_PORTS; p++) begin
                    if (wr_q[p] && addrWr_i[p*INDEX +: INDEX] == ra) begin
                        rd = dataWr_i[p*WIDTH +: WIDTH];
                    end
                end
            end
            if (ramReady_o && !readPortGated_i[r] && !ent_gated[ra]) begin
                data_o[r*WIDTH +: WIDTH] = rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state == CLEAR) begin
            assert (wrEn_i == '0)
            else $error("lsq_cfg_ram: write enable while clearing");
        end
    end

endmodule

// File: tb/tb_lsq_cfg_ram.sv
// tb_lsq_cfg_ram: two builds (plain 2R, sequential-clear bypass 1R) driven
// by shared directed stimulus; a negedge monitor checks queued expectations.
module tb_lsq_cfg_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_wr;
    logic [31:0] data_wr;
    logic [3:0]  wr_en;
    logic [3:0]  wp_gated;
    logic [7:0]  rd_addr;
    logic [1:0]  rp_gated;
    logic [3:0]  part_gated;
    logic [15:0] rdata_a;
    logic [7:0]  rdata_b;
    logic        rdy_a;
    logic        rdy_b;

    typedef struct {
        string      name;
        int         src;
        logic [7:0] val;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] act;
    logic       smp;
    int         n_chk;
    int         n_fail;

    always #5 clk = ~clk;

    lsq_cfg_ram #(
        .NUM_RD_PORTS(2), .SEQ_START(0), .RESET_VAL(8'hA5), .BYPASS(0)
    ) u_a (
        .clk(clk), .reset(reset),
        .addrWr_i(addr_wr), .dataWr_i(data_wr),
        .wrEn_i(wr_en), .writePortGated_i(wp_gated),
        .addr_i(rd_addr), .data_o(rdata_a),
        .readPortGated_i(rp_gated), .partitionGated_i(part_gated),
        .ramReady_o(rdy_a)
    );

    lsq_cfg_ram #(
        .NUM_RD_PORTS(1), .SEQ_START(1), .BYPASS(1)
    ) u_b (
        .clk(clk), .reset(reset),
        .addrWr_i(addr_wr), .dataWr_i(data_wr),
        .wrEn_i(wr_en), .writePortGated_i(wp_gated),
        .addr_i(rd_addr[3:0]), .data_o(rdata_b),
        .readPortGated_i(rp_gated[0]), .partitionGated_i(part_gated),
        .ramReady_o(rdy_b)
    );

    // src: 0 A rd0, 1 A rd1, 2 B rd0, 3 A ready, 4 B ready
    always @(negedge clk) begin
        if (smp) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.src)
                    0:       act = rdata_a[7:0];
                    1:       act = rdata_a[15:8];
                    2:       act = rdata_b;
                    3:       act = {7'b0, rdy_a};
                    default: act = {7'b0, rdy_b};
                endcase
                n_chk++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        smp   = 1'b0;
        wr_en = '0;
    endtask

    task automatic expect_v(input string n, input int src, input logic [7:0] v);
        exp_t x;
        x.name = n;
        x.src  = src;
        x.val  = v;
        q.push_back(x);
        smp = 1'b1;
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [7:0] d);
        addr_wr[p*4 +: 4] = a;
        data_wr[p*8 +: 8] = d;
        wr_en[p]          = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Reset is released on entry; ready must rise after exactly 16 edges.
    task automatic clear_seq(input string tag);
        reset = 1'b1;
        rd(4'd7, 4'd0);
        for (int j = 0; j <= 16; j++) begin
            expect_v($sformatf("%s_rdyA_%0d", tag, j), 3, (j == 16) ? 8'd1 : 8'd0);
            expect_v($sformatf("%s_rdyB_%0d", tag, j), 4, (j == 16) ? 8'd1 : 8'd0);
            expect_v($sformatf("%s_datA_%0d", tag, j), 0, (j == 16) ? 8'hA5 : 8'h00);
            expect_v($sformatf("%s_datB_%0d", tag, j), 2, (j == 16) ? 8'h07 : 8'h00);
            cyc();
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        smp        = 1'b0;
        reset      = 1'b0;
        addr_wr    = '0;
        data_wr    = '0;
        wr_en      = '0;
        wp_gated   = '0;
        rd_addr    = '0;
        rp_gated   = '0;
        part_gated = '0;

        cyc();
        cyc();
        expect_v("rst_rdyA", 3, 8'd0);
        expect_v("rst_rdyB", 4, 8'd0);
        expect_v("rst_datA", 0, 8'h00);
        expect_v("rst_datB", 2, 8'h00);
        cyc();
        clear_seq("clr1");

        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i));
            expect_v($sformatf("all_A0_%0d", i), 0, 8'hA5);
            expect_v($sformatf("all_A1_%0d", i), 1, 8'hA5);
            expect_v($sformatf("all_B_%0d", i), 2, 8'(i));
            cyc();
        end
        rd(4'd15, 4'd0);
        expect_v("seq_B15", 2, 8'h0F);
        cyc();

        // Restart: reassert reset five cycles into a clear.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int j = 0; j < 5; j++) begin
            expect_v($sformatf("rst5_rdyA_%0d", j), 3, 8'd0);
            expect_v($sformatf("rst5_rdyB_%0d", j), 4, 8'd0);
            cyc();
        end
        reset = 1'b0;
        expect_v("rst5_hold", 3, 8'd0);
        cyc();
        clear_seq("clr2");

        // Write conflict on address 3, plus a parallel write to address 9.
        wr(0, 4'd3, 8'h11);
        wr(1, 4'd9, 8'h44);
        wr(2, 4'd3, 8'h22);
        wr(3, 4'd3, 8'h33);
        rd(4'd3, 4'd9);
        expect_v("conf_A_same", 0, 8'hA5);
        expect_v("conf_B_byp", 2, 8'h33);
        cyc();
        expect_v("conf_A3", 0, 8'h33);
        expect_v("conf_A9", 1, 8'h44);
        expect_v("conf_B3", 2, 8'h33);
        cyc();
        rd(4'd9, 4'd3);
        expect_v("conf_B9", 2, 8'h44);
        cyc();

        // Gated write port.
        wp_gated[3] = 1'b1;
        wr(3, 4'd2, 8'hFF);
        rd(4'd2, 4'd2);
        expect_v("wpg_A_same", 0, 8'hA5);
        expect_v("wpg_B_nobyp", 2, 8'h02);
        cyc();
        expect_v("wpg_A2", 0, 8'hA5);
        expect_v("wpg_B2", 2, 8'h02);
        cyc();
        wp_gated = '0;

        // Partition gating retains contents.
        wr(0, 4'd5, 8'h5A);
        rd(4'd5, 4'd3);
        expect_v("pg_A_pre", 0, 8'hA5);
        expect_v("pg_B_byp", 2, 8'h5A);
        cyc();
        part_gated = 4'b0010;
        wr(0, 4'd5, 8'h00);
        expect_v("pg_A_gated", 0, 8'h00);
        expect_v("pg_A_other", 1, 8'h33);
        expect_v("pg_B_gated", 2, 8'h00);
        cyc();
        expect_v("pg_A_gated2", 0, 8'h00);
        expect_v("pg_B_gated2", 2, 8'h00);
        cyc();
        part_gated = '0;
        expect_v("pg_A_kept", 0, 8'h5A);
        expect_v("pg_B_kept", 2, 8'h5A);
        cyc();

        // Bypass versus array read.
        wr(1, 4'd4, 8'hC3);
        rd(4'd4, 4'd3);
        expect_v("byp_A_old", 0, 8'hA5);
        expect_v("byp_B_new", 2, 8'hC3);
        cyc();
        expect_v("byp_A_next", 0, 8'hC3);
        expect_v("byp_B_next", 2, 8'hC3);
        cyc();

        // Read port gating.
        rp_gated = 2'b10;
        rd(4'd3, 4'd3);
        expect_v("rpg_A0", 0, 8'h33);
        expect_v("rpg_A1", 1, 8'h00);
        cyc();
        rp_gated = 2'b01;
        expect_v("rpg0_A0", 0, 8'h00);
        expect_v("rpg0_A1", 1, 8'h33);
        expect_v("rpg0_B", 2, 8'h00);
        cyc();
        rp_gated = '0;
        expect_v("rpg_off_A1", 1, 8'h33);
        expect_v("rpg_off_B", 2, 8'h33);
        cyc();

        cyc();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsq_cfg_ram.md
Name: lsq_cfg_ram

Overview:
- Parametrised multi-write, multi-read register-file RAM for LSQ side-tables, e.g. store-queue following-load and load-queue following-store fields.
- Generalises the fixed 1R/DISPATCH_WIDTH-W LSQ RAMs in four ways: configurable port counts, per-port and per-partition gating for DYNAMIC_CONFIG, optional write-to-read bypass, and a self-clearing reset sequencer with a ready handshake.
- Sits inside the LSQ, written at dispatch and read at execute/commit.

Parameters:
- DEPTH, 16, number of entries; must be a multiple of NUM_PARTS.
- INDEX, 4, address width; equals clog2(DEPTH).
- WIDTH, 8, entry width in bits.
- NUM_WR_PORTS, 4, number of write ports (1..8).
- NUM_RD_PORTS, 1, number of read ports (1..4).
- NUM_PARTS, 4, number of equal-size partitions that can be gated.
- SEQ_START, 0, clear mode: 0 = every entry cleared to RESET_VAL; 1 = entry i cleared to i (truncated to WIDTH).
- RESET_VAL, 0, clear value used when SEQ_START=0.
- BYPASS, 0, 1 = a read sees the data written to the same address in the same cycle.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-low reset (asserted when 0).
- addrWr_i, in, NUM_WR_PORTS*INDEX, write addresses; port p uses bits [p*INDEX +: INDEX].
- dataWr_i, in, NUM_WR_PORTS*WIDTH, write data; port p uses bits [p*WIDTH +: WIDTH].
- wrEn_i, in, NUM_WR_PORTS, per-port write enable.
- writePortGated_i, in, NUM_WR_PORTS, 1 = port disabled.
- addr_i, in, NUM_RD_PORTS*INDEX, read addresses.
- data_o, out, NUM_RD_PORTS*WIDTH, read data.
- readPortGated_i, in, NUM_RD_PORTS, 1 = read port disabled.
- partitionGated_i, in, NUM_PARTS, 1 = partition disabled.
- ramReady_o, out, 1, 1 = clear sequence complete; accesses are accepted.

Behaviour:
- Partition of entry a is a / (DEPTH/NUM_PARTS).
- FSM has two states, CLEAR and READY.
- Reset: reset==0 at a posedge sends the FSM to CLEAR, sets clrPtr to 0 and ramReady_o to 0.
  - The array is not cleared in that cycle.
  - Reset asserted mid-CLEAR or in READY restarts the sequence from entry 0.
- CLEAR state:
  - Each cycle with reset==1, write the clear value to entry clrPtr, then clrPtr++.
  - The cycle that writes entry DEPTH-1 moves the FSM to READY; ramReady_o is 1 from the next cycle.
  - After reset deasserts, clearing takes exactly DEPTH cycles.
  - All functional writes are dropped and all data_o are 0.
  - Gated partitions are still cleared.
- READY writes (1-cycle latency):
  - Port p writes when wrEn_i[p] & ~writePortGated_i[p] and the target partition is not gated; otherwise the write is dropped.
  - Same-address conflict: the highest-numbered enabled port wins.
  - Different addresses from different ports all commit in the same cycle.
- READY reads (combinational, 0 latency):
  - data_o[r] is 0 if readPortGated_i[r], the target partition is gated, or ramReady_o==0.
  - With BYPASS=0: returns the array content, i.e. the pre-write value when a same-cycle write targets that address.
  - With BYPASS=1: returns the winning same-cycle write data if any qualified write hits the address, else the array content.
- Gating is state-preserving.
  - Contents of a gated partition are retained.
  - After ungating, reads return the last value written before gating.
- Out-of-range addresses cannot occur because DEPTH = 2^INDEX; no wrap logic is needed.
- Outputs after reset: ramReady_o=0, data_o=0.
- Assertions (sim only):
  - DEPTH % NUM_PARTS == 0.
  - INDEX == clog2(DEPTH).
  - No wrEn_i during CLEAR; flag it, the write is still dropped.

Test Plan:
- Clear, RESET_VAL: DEPTH=16, SEQ_START=0, RESET_VAL=8'hA5. Deassert reset, then read every entry. Required: ramReady_o rises exactly 16 cycles after deassert, and all entries read 8'hA5.
- Clear, sequential: SEQ_START=1. After ready, entry 7 reads 8'h07 and entry 15 reads 8'h0F. Reassert reset at cycle 5 of the clear: ramReady_o stays 0 and the sequence takes a full 16 cycles again from deassert.
- Write conflict: ports 0, 2 and 3 all write address 3 with 8'h11, 8'h22, 8'h33. Required: next cycle addr 3 reads 8'h33. In the same cycle port 1 writes addr 9 with 8'h44; required: addr 9 reads 8'h44.
- Port gating: writePortGated_i[3]=1 and port 3 writes addr 2 with 8'hFF. Required: addr 2 keeps its prior value.
- Partition gating: NUM_PARTS=4. Write addr 5 with 8'h5A, set partitionGated_i[1]=1, read addr 5 and write addr 5 with 8'h00. Required: data_o=0 while gated; after ungating, addr 5 reads 8'h5A.
- Bypass: write addr 4 with 8'hC3 and read addr 4 in the same cycle. Required: BYPASS=1 returns 8'hC3 that cycle; BYPASS=0 returns the old value that cycle and 8'hC3 the following cycle.
- Ready gating: with readPortGated_i[1]=1 on a 2-read-port build, data_o port 1 is 0. Also, any read issued before ramReady_o rises returns 0.
